// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and helpers for the APB4 memory completer
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_slv_state_e;

    localparam int unsigned ERR_CNT_W = 8;

    // Byte offset from BASE_ADDR to word index; strb_w is the bytes per word.
    function automatic logic [63:0] word_idx(input logic [63:0] byte_off, input int unsigned strb_w);
        return byte_off / 64'(strb_w);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - single-port word RAM with byte-lane write enables and combinational read
module apb_mem_array #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   wstrb,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(DW / 8); i++) begin
                if (wstrb[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/apb4_mem_slave.sv
// rtl/apb4_mem_slave.sv - APB4 completer over byte-lane word memory with programmable wait states
module apb4_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned       APB_DW    = 32,
    parameter int unsigned       APB_AW    = 32,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [APB_AW-1:0] BASE_ADDR = '0,
    parameter int unsigned       WAIT_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_AW-1:0]     paddr,
    input  logic [APB_DW-1:0]     pwdata,
    input  logic [APB_DW/8-1:0]   pstrb,
    output logic [APB_DW-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [WAIT_W-1:0]     cfg_wait,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int unsigned STRB_W = APB_DW / 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] SIZE_B = 64'(DEPTH) * 64'(STRB_W);

    if (APB_DW % 8 != 0) begin : g_dw_chk
        $error("APB_DW must be a multiple of 8");
    end
    if (DEPTH < 1) begin : g_depth_chk
        $error("DEPTH must be at least 1");
    end
    if (64'(BASE_ADDR) % 64'(STRB_W) != 0) begin : g_base_chk
        $error("BASE_ADDR must be word aligned");
    end
    if ((APB_AW < 64) && (64'(BASE_ADDR) + SIZE_B > (64'd1 << APB_AW))) begin : g_wrap_chk
        $error("BASE_ADDR + memory size wraps the address space");
    end

    apb_slv_state_e        state_q, state_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [APB_DW-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [APB_DW-1:0]     prdata_q, prdata_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [APB_AW-1:0]     off;
    logic                  setup_err;
    logic [IDX_W-1:0]      setup_idx;
    logic [IDX_W-1:0]      mem_addr;
    logic [APB_DW-1:0]     mem_rdata;
    logic                  mem_we;

    assign off       = paddr - BASE_ADDR;
    assign setup_err = (paddr < BASE_ADDR) || (64'(off) >= SIZE_B) ||
                       (64'(off) % 64'(STRB_W) != 0) || (pwrite && (pstrb == '0));
    assign setup_idx = IDX_W'(word_idx(64'(off), STRB_W));

    // In IDLE the RAM is addressed straight from the bus so zero-wait reads have data in time.
    assign mem_addr = (state_q == IDLE) ? setup_idx : idx_q;

    apb_mem_array #(
        .DW    (APB_DW),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we && reset_n),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        err_cnt_d = err_cnt_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                if (psel && !penable) begin
                    idx_d   = setup_idx;
                    write_d = pwrite;
                    err_d   = setup_err;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    if (cfg_wait == '0) begin
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                        prdata_d  = (!pwrite && !setup_err) ? mem_rdata : '0;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = cfg_wait;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = IDLE;
                end else if (cnt_q == WAIT_W'(1)) begin
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    prdata_d  = (!write_q && !err_q) ? mem_rdata : '0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                state_d   = IDLE;
                if (psel && penable) begin
                    if (err_q) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else begin
                        mem_we = write_q;
                    end
                end else if (!psel) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// tb/tb_apb4_mem_slave.sv - directed self-checking bench for apb4_mem_slave
module tb_apb4_mem_slave;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [3:0]  cfg_wait;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    apb4_mem_slave #(
        .APB_DW    (32),
        .APB_AW    (32),
        .DEPTH     (256),
        .BASE_ADDR (BASE),
        .WAIT_W    (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .cfg_wait (cfg_wait),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transfer starting at a negedge; returns at the negedge after the completion edge.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st, input logic [3:0] wt,
                        input logic [31:0] exp_rd, input logic exp_err);
        int n;
        cfg_wait = wt;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(negedge clk);
        penable  = 1'b1;
        cfg_wait = ~wt;
        n = 0;
        while (!pready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_waits"}, 32'(n), 32'(wt));
        chk({tag, "_pready"}, 32'(pready), 32'd1);
        chk({tag, "_pslverr"}, 32'(pslverr), 32'(exp_err));
        if (!wr) chk({tag, "_prdata"}, prdata, exp_rd);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        cfg_wait = wt;
        chk({tag, "_pready_low"}, 32'(pready), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; cfg_wait = '0;
        repeat (3) @(negedge clk);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        xfer("t1_wr", 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 4'd0, 32'h0, 1'b0);
        xfer("t1_rd", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 4'd0, 32'hDEADBEEF, 1'b0);

        xfer("t2_rd", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 4'd3, 32'hDEADBEEF, 1'b0);

        xfer("t3_wr", 1'b1, BASE + 32'h10, 32'h11223344, 4'b0101, 4'd0, 32'h0, 1'b0);
        xfer("t3_rd", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 4'd1, 32'hDE22BE44, 1'b0);

        xfer("t4_wr_oor", 1'b1, BASE + 32'd1024, 32'hFFFFFFFF, 4'hF, 4'd0, 32'h0, 1'b1);
        xfer("t4_wr_mis", 1'b1, BASE + 32'h2, 32'hFFFFFFFF, 4'hF, 4'd2, 32'h0, 1'b1);
        chk("t4_err_cnt2", 32'(err_cnt), 32'd2);
        xfer("t4_rd_keep", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 4'd0, 32'hDE22BE44, 1'b0);
        xfer("t4_rd_oor", 1'b0, BASE + 32'd1024, 32'h0, 4'h0, 4'd0, 32'h0, 1'b1);
        xfer("t4_wr_nostrb", 1'b1, BASE + 32'h10, 32'h0, 4'h0, 4'd0, 32'h0, 1'b1);
        xfer("t4_rd_below", 1'b0, BASE - 32'h4, 32'h0, 4'h0, 4'd0, 32'h0, 1'b1);
        chk("t4_err_cnt5", 32'(err_cnt), 32'd5);
        xfer("t4_rd_keep2", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 4'd0, 32'hDE22BE44, 1'b0);
        xfer("t4_last_wr", 1'b1, BASE + 32'd1020, 32'hA5A5A5A5, 4'hF, 4'd0, 32'h0, 1'b0);
        xfer("t4_last_rd", 1'b0, BASE + 32'd1020, 32'h0, 4'h0, 4'd0, 32'hA5A5A5A5, 1'b0);

        xfer("t5_pre", 1'b1, BASE + 32'h20, 32'h0BADF00D, 4'hF, 4'd0, 32'h0, 1'b0);
        cfg_wait = 4'd5;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h20;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        chk("t5_acc1_pready", 32'(pready), 32'd0);
        @(negedge clk);
        chk("t5_acc2_pready", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("t5_idle_pready", 32'(pready), 32'd0);
        chk("t5_err_cnt", 32'(err_cnt), 32'd6);
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_pready", 32'(pready), 32'd0);
        end
        xfer("t5_rd", 1'b0, BASE + 32'h20, 32'h0, 4'h0, 4'd0, 32'h0BADF00D, 1'b0);

        xfer("t6_pre", 1'b1, BASE + 32'h30, 32'h5555AAAA, 4'hF, 4'd0, 32'h0, 1'b0);
        cfg_wait = 4'd4;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h30;
        pwdata = 32'h0; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_pready", 32'(pready), 32'd0);
        chk("t6_prdata", prdata, 32'd0);
        chk("t6_err_cnt", 32'(err_cnt), 32'd0);
        reset_n = 1'b1; psel = 1'b0; penable = 1'b0;
        repeat (6) @(negedge clk);
        xfer("t6_rd", 1'b0, BASE + 32'h30, 32'h0, 4'h0, 4'd0, 32'h5555AAAA, 1'b0);
        chk("t6_err_cnt_end", 32'(err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
